// File: rtl/acs_survivor_mem.sv
// acs_survivor_mem: add-compare-select and survivor memory for a 4-state K=3 (7,5) Viterbi decoder.
// Collects one frame of decisions, picks the best end state, then replays decisions newest-first.
module acs_survivor_mem #(
    parameter int N_STEPS = 8,
    parameter int PM_W    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [1:0] i_sym,
    output logic       o_ready,
    output logic [1:0] o_slt_node,
    output logic       o_en_trbk,
    output logic [1:0] o_bck_prev_st_00,
    output logic [1:0] o_bck_prev_st_01,
    output logic [1:0] o_bck_prev_st_10,
    output logic [1:0] o_bck_prev_st_11
);
    localparam int PTR_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_STEPS - 1);
    localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W-1){1'b0}}};

    typedef enum logic [1:0] {ACS, SEL, TRBK, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [PM_W-1:0]  pm_q [4];
    logic [PM_W-1:0]  pm_d [4];
    logic [3:0]       mem_q [N_STEPS];
    logic [3:0]       mem_d [N_STEPS];
    logic [PTR_W-1:0] step_q, step_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]       slt_node_q, slt_node_d;
    logic             en_trbk_q, en_trbk_d;
    logic [PM_W-1:0]  acs_pm [4];
    logic [3:0]       dec;
    logic [1:0]       best;
    logic [3:0]       rd_dec;

    // Candidate metric through predecessor p with input u, clamped at the top of the range.
    function automatic logic [PM_W-1:0] cand(input logic [PM_W-1:0] pm, input logic [1:0] p,
                                             input logic u, input logic [1:0] sym);
        logic [1:0]  e;
        logic [PM_W:0] s;
        e = sym ^ {u ^ p[1] ^ p[0], u ^ p[0]};
        s = {1'b0, pm} + {{PM_W{1'b0}}, e[1]} + {{PM_W{1'b0}}, e[0]};
        return s[PM_W] ? '1 : s[PM_W-1:0];
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_acs
        localparam logic [1:0] ST = 2'(i);
        localparam logic [1:0] P0 = {ST[0], 1'b0};
        localparam logic [1:0] P1 = {ST[0], 1'b1};
        logic [PM_W-1:0] c0, c1;
        assign c0        = cand(pm_q[P0], P0, ST[1], i_sym);
        assign c1        = cand(pm_q[P1], P1, ST[1], i_sym);
        assign dec[i]    = c1 < c0;
        assign acs_pm[i] = dec[i] ? c1 : c0;
    end

    // Lowest index wins ties because only a strictly smaller metric displaces it.
    always_comb begin
        best = 2'd0;
        for (int n = 1; n < 4; n++)
            if (pm_q[n] < pm_q[best]) best = 2'(n);
    end

    always_comb begin
        state_d    = state_q;
        pm_d       = pm_q;
        mem_d      = mem_q;
        step_d     = step_q;
        rd_ptr_d   = rd_ptr_q;
        slt_node_d = slt_node_q;
        en_trbk_d  = en_trbk_q;
        case (state_q)
            ACS: if (i_valid) begin
                pm_d          = acs_pm;
                mem_d[step_q] = dec;
                step_d        = step_q + 1'b1;
                state_d       = (step_q == LAST) ? SEL : ACS;
            end
            SEL: begin
                slt_node_d = best;
                rd_ptr_d   = LAST;
                en_trbk_d  = 1'b1;
                state_d    = TRBK;
            end
            TRBK: begin
                rd_ptr_d  = rd_ptr_q - 1'b1;
                en_trbk_d = rd_ptr_q != '0;
                state_d   = (rd_ptr_q == '0) ? DRAIN : TRBK;
            end
            default: begin
                for (int n = 0; n < 4; n++) pm_d[n] = (n == 0) ? '0 : PM_INIT;
                step_d  = '0;
                state_d = ACS;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACS;
            for (int n = 0; n < 4; n++) pm_q[n] <= (n == 0) ? '0 : PM_INIT;
            for (int n = 0; n < N_STEPS; n++) mem_q[n] <= '0;
            step_q     <= '0;
            rd_ptr_q   <= '0;
            slt_node_q <= '0;
            en_trbk_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pm_q       <= pm_d;
            mem_q      <= mem_d;
            step_q     <= step_d;
            rd_ptr_q   <= rd_ptr_d;
            slt_node_q <= slt_node_d;
            en_trbk_q  <= en_trbk_d;
        end
    end

    assign rd_dec           = mem_q[rd_ptr_q];
    assign o_ready          = state_q == ACS;
    assign o_slt_node       = slt_node_q;
    assign o_en_trbk        = en_trbk_q;
    assign o_bck_prev_st_00 = {1'b0, rd_dec[0]};
    assign o_bck_prev_st_01 = {1'b1, rd_dec[1]};
    assign o_bck_prev_st_10 = {1'b0, rd_dec[2]};
    assign o_bck_prev_st_11 = {1'b1, rd_dec[3]};
endmodule

// File: tb/tb_acs_survivor_mem.sv
// tb_acs_survivor_mem: directed frames checked every cycle against a forward-relaxation trellis model,
// plus literal expectations for the hand-decoded frames.
module tb_acs_survivor_mem;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_valid = 1'b0;
    logic [1:0] i_sym = 2'b00;
    logic       o_ready, o_en_trbk;
    logic [1:0] o_slt_node;
    logic [1:0] o_bck_prev_st_00, o_bck_prev_st_01, o_bck_prev_st_10, o_bck_prev_st_11;
    logic [1:0] dprev [4];

    acs_survivor_mem dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sym(i_sym), .o_ready(o_ready),
        .o_slt_node(o_slt_node), .o_en_trbk(o_en_trbk),
        .o_bck_prev_st_00(o_bck_prev_st_00), .o_bck_prev_st_01(o_bck_prev_st_01),
        .o_bck_prev_st_10(o_bck_prev_st_10), .o_bck_prev_st_11(o_bck_prev_st_11)
    );

    assign dprev[0] = o_bck_prev_st_00;
    assign dprev[1] = o_bck_prev_st_01;
    assign dprev[2] = o_bck_prev_st_10;
    assign dprev[3] = o_bck_prev_st_11;

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 accepting, 1 selecting, 2 playing back, 3 reinitialising.
    int m_phase, m_cnt, m_k, m_slt, m_minpm;
    int m_pm [4];
    int m_prev [8][4];

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_k = 0; m_slt = 0;
        m_pm[0] = 0; m_pm[1] = 32; m_pm[2] = 32; m_pm[3] = 32;
        for (int s = 0; s < 8; s++) for (int n = 0; n < 4; n++) m_prev[s][n] = n / 2 * 0 + (n % 2) * 2;
    endtask

    // Relax every (state, input) branch forward; earlier predecessor keeps a tie.
    task automatic model_acs(input logic [1:0] sym);
        int np [4];
        int win [4];
        for (int n = 0; n < 4; n++) begin np[n] = 1000; win[n] = 0; end
        for (int p = 0; p < 4; p++) begin
            for (int u = 0; u < 2; u++) begin
                int a, b, n, c0, c1, c;
                a = p / 2; b = p % 2; n = u * 2 + a;
                c0 = u ^ a ^ b; c1 = u ^ b;
                c = m_pm[p] + (int'(sym[1]) ^ c0) + (int'(sym[0]) ^ c1);
                if (c > 63) c = 63;
                if (c < np[n]) begin np[n] = c; win[n] = p; end
            end
        end
        m_pm = np;
        m_prev[m_cnt] = win;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else case (m_phase)
                0: if (i_valid) begin
                    model_acs(i_sym);
                    m_cnt++;
                    if (m_cnt == 8) m_phase = 1;
                end
                1: begin
                    m_slt = 0;
                    for (int n = 1; n < 4; n++) if (m_pm[n] < m_pm[m_slt]) m_slt = n;
                    m_minpm = m_pm[m_slt];
                    m_k = 0;
                    m_phase = 2;
                end
                2: begin
                    m_k++;
                    if (m_k == 8) m_phase = 3;
                end
                default: begin
                    m_pm[0] = 0; m_pm[1] = 32; m_pm[2] = 32; m_pm[3] = 32;
                    m_cnt = 0;
                    m_phase = 0;
                end
            endcase
        end
    end

    logic [1:0] cap [8][4];
    logic [1:0] ref_cap [8][4];
    int en_cnt = 0;
    int en_len = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) en_cnt = 0;
        else begin
            chk("ready", o_ready, m_phase == 0);
            chk("en_trbk", o_en_trbk, m_phase == 2);
            chk("slt_node", o_slt_node, m_slt);
            if (m_phase == 2)
                for (int n = 0; n < 4; n++) chk($sformatf("prev_st_%0d_step%0d", n, 7 - m_k), dprev[n], m_prev[7 - m_k][n]);
            if (o_en_trbk) begin
                if (en_cnt < 8) for (int n = 0; n < 4; n++) cap[7 - en_cnt][n] = dprev[n];
                en_cnt++;
            end else if (en_cnt != 0) begin
                en_len = en_cnt;
                en_cnt = 0;
            end
        end
    end

    task automatic send(input logic [1:0] s, input int gap);
        repeat (gap) begin @(negedge clk); i_valid = 1'b0; end
        @(negedge clk);
        i_valid = 1'b1;
        i_sym = s;
        for (int t = 0; t < 40 && o_ready !== 1'b1; t++) @(negedge clk);
        chk("ready_wait", o_ready, 1);
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [15:0] f, input int gap);
        for (int k = 0; k < 8; k++) send(f[15 - 2 * k -: 2], gap);
    endtask

    task automatic finish_frame();
        @(negedge clk);
        i_valid = 1'b0;
        for (int t = 0; t < 20 && o_en_trbk !== 1'b1; t++) @(negedge clk);
        chk("en_rise_timeout", o_en_trbk, 1);
        for (int t = 0; t < 20 && o_en_trbk !== 1'b0; t++) @(negedge clk);
        chk("en_fall_timeout", o_en_trbk, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_path(input string tag);
        chk({tag, "_slt"}, o_slt_node, 0);
        chk({tag, "_step2_prev00"}, cap[2][0], 1);
        chk({tag, "_step1_prev01"}, cap[1][1], 2);
        chk({tag, "_step0_prev10"}, cap[0][2], 0);
        chk({tag, "_en_len"}, en_len, 8);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_en", o_en_trbk, 0);
        chk("rst_slt", o_slt_node, 0);
        rst = 1'b1;

        send_frame(16'h0000, 0);
        finish_frame();
        chk("zeros_slt", o_slt_node, 0);
        chk("zeros_en_len", en_len, 8);
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("zeros_prev00_s%0d", s), cap[s][0], 0);
            chk($sformatf("zeros_prev10_s%0d", s), cap[s][2], 0);
        end

        send_frame(16'hEC00, 0);
        finish_frame();
        chk_path("path");
        chk("path_model_minpm", m_minpm, 0);
        ref_cap = cap;

        send_frame(16'hED00, 0);
        finish_frame();
        chk_path("flip");
        chk("flip_model_minpm", m_minpm, 1);

        // Valid stays high with symbol 11 through SEL/TRBK/DRAIN; 11 must open the next frame.
        send_frame(16'h0000, 0);
        send_frame(16'hEC00, 0);
        finish_frame();
        chk_path("held");

        send_frame(16'hEC00, 2);
        finish_frame();
        chk_path("gaps");
        for (int s = 0; s < 8; s++)
            for (int n = 0; n < 4; n++) chk($sformatf("gaps_cap_s%0d_n%0d", s, n), cap[s][n], ref_cap[s][n]);

        send_frame(16'hEC00, 0);
        @(negedge clk);
        i_valid = 1'b0;
        for (int t = 0; t < 20 && o_en_trbk !== 1'b1; t++) @(negedge clk);
        chk("mid_en_rise", o_en_trbk, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_en", o_en_trbk, 0);
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_slt", o_slt_node, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_frame(16'hEC00, 0);
        finish_frame();
        chk_path("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
